// File: rtl/calc_pkg.sv
// Shared calculator types and widths.
// No logic; types and localparams only.
// No flow control.
package calc_pkg;

  localparam int CALC_OP_W  = 14;
  localparam int CALC_RES_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer.sv
// Iterative shift-add unsigned multiplier feeding the accumulator mux mul_res operand.
// Latency OP_W+1 cycles start-to-done (1 cycle when either operand is zero).
// No backpressure: start is ignored while busy; stall freezes PC/accumulator during RUN.
module mul_sequencer
  import calc_pkg::*;
#(
  parameter int OP_W  = CALC_OP_W,
  parameter int RES_W = CALC_RES_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [RES_W-1:0] result
);

  localparam int CNT_W = $clog2(OP_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_W - 1);

  mul_state_t       state_q;
  mul_state_t       state_d;
  logic [RES_W-1:0] mcand;
  logic [OP_W-1:0]  mplier;
  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [RES_W-1:0] acc_sum;
  logic             load;
  logic             zero_load;
  logic             finish;

  // Partial-product add for the current multiplier bit; carry out is dropped
  // because the full product always fits in RES_W.
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control; start is honoured in IDLE and DONE alike.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    zero_load = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (op_a == '0 || op_b == '0) begin
            zero_load = 1'b1;
            state_d   = DONE;
          end else begin
            load    = 1'b1;
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (count == LAST_CNT) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-add datapath: capture operands on accept, one multiplier bit per RUN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= RES_W'(op_a);
      mplier <= op_b;
      acc    <= '0;
      count  <= '0;
    end else if (state_q == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  // Result only moves on the edge entering DONE, so the old product is held
  // through a back-to-back multiply.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
    end else if (zero_load) begin
      result <= '0;
    end else if (finish) begin
      result <= acc_sum;
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = busy;
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer.
// Drives and samples 1 time unit after the rising edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_mul_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [13:0] op_a;
  logic [13:0] op_b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  int n;
  logic seen_done;

  mul_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [13:0] a, input logic [13:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles while busy, bounded so a stuck FSM still reaches the summary.
  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b1;
    tick();

    // 3*5
    issue(14'd3, 14'd5);
    chk("basic_stall_on", 32'(stall), 32'd1);
    wait_busy(n);
    chk("basic_cycles", 32'(n), 32'd14);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_result", result, 32'd15);
    chk("basic_stall_off", 32'(stall), 32'd0);
    tick();
    chk("basic_done_pulse", 32'(done), 32'd0);

    // 16383*16383
    issue(14'h3FFF, 14'h3FFF);
    wait_busy(n);
    chk("max_cycles", 32'(n), 32'd14);
    chk("max_done", 32'(done), 32'd1);
    chk("max_result", result, 32'd268402689);
    tick();

    // Zero shortcut, op_a == 0
    issue(14'd0, 14'd1234);
    chk("zero_a_busy", 32'(busy), 32'd0);
    chk("zero_a_done", 32'(done), 32'd1);
    chk("zero_a_result", result, 32'd0);
    tick();
    chk("zero_a_idle", 32'(done), 32'd0);

    // Zero shortcut, op_b == 0
    issue(14'd77, 14'd0);
    chk("zero_b_busy", 32'(busy), 32'd0);
    chk("zero_b_done", 32'(done), 32'd1);
    chk("zero_b_result", result, 32'd0);
    tick();

    // Start during RUN is ignored
    issue(14'd7, 14'd9);
    tick();
    tick();
    tick();
    start = 1'b1;
    op_a  = 14'd100;
    op_b  = 14'd100;
    tick();
    start = 1'b0;
    wait_busy(n);
    chk("ign_cycles", 32'(n), 32'd10);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_result", result, 32'd63);
    tick();
    chk("ign_idle_busy", 32'(busy), 32'd0);
    chk("ign_idle_done", 32'(done), 32'd0);

    // Back-to-back: restart from DONE
    issue(14'd7, 14'd9);
    wait_busy(n);
    chk("b2b_first_done", 32'(done), 32'd1);
    chk("b2b_first_result", result, 32'd63);
    start = 1'b1;
    op_a  = 14'd12;
    op_b  = 14'd12;
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_hold_result", result, 32'd63);
    wait_busy(n);
    chk("b2b_cycles", 32'(n), 32'd14);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_result", result, 32'd144);
    tick();

    // Asynchronous reset in the middle of RUN
    issue(14'd1000, 14'd1000);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    #3;
    reset = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_result_after", result, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
